// File: rtl/adder_operand_loader.sv
// adder_operand_loader: byte-serial operand front end and result register for
// the 64-bit carry-lookahead adder. Assembles A, B (LSB byte first) and carry-in,
// holds them on the adder inputs, then registers sum/carry for a valid/ready
// result handshake.
// Optional feature: define LOADER_OVF_EN to register two's-complement signed
// overflow on res_ovf; otherwise res_ovf is tied to 0.
module adder_operand_loader #(
   parameter int DATA_W = 64,
   parameter int IN_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IN_W-1:0]   in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_cin,
   output logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic              c_in,
   input  logic [DATA_W-1:0] sum,
   input  logic              c_out,
   output logic [DATA_W-1:0] res_sum,
   output logic              res_carry,
   output logic              res_ovf,
   output logic              res_valid,
   input  logic              res_ready
);

   localparam int NB = DATA_W / IN_W;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;

   typedef enum logic [1:0] {LOAD_A, LOAD_B, ADD, HOLD} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic              c_in_q, c_in_d;
   logic [DATA_W-1:0] res_sum_q, res_sum_d;
   logic              res_carry_q, res_carry_d;
   logic              last_byte;

   assign last_byte = (cnt_q == CW'(NB - 1));

   // Next-state: byte assembly, result capture in ADD, release on handshake
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      c_in_d      = c_in_q;
      res_sum_d   = res_sum_q;
      res_carry_d = res_carry_q;
      case (state_q)
         LOAD_A: if (in_valid) begin
            for (int i = 0; i < NB; i++)
               if (cnt_q == CW'(i)) a_d[i*IN_W +: IN_W] = in_data;
            if (last_byte) begin
               cnt_d   = '0;
               state_d = LOAD_B;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LOAD_B: if (in_valid) begin
            for (int i = 0; i < NB; i++)
               if (cnt_q == CW'(i)) b_d[i*IN_W +: IN_W] = in_data;
            if (last_byte) begin
               cnt_d   = '0;
               c_in_d  = in_cin;
               state_d = ADD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ADD: begin
            // operands have been stable for a full cycle; adder output is settled
            res_sum_d   = sum;
            res_carry_d = c_out;
            state_d     = HOLD;
         end
         default: if (res_ready) state_d = LOAD_A;
      endcase
   end

   // State and datapath registers; reset discards partial operands and results
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= LOAD_A;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         c_in_q      <= 1'b0;
         res_sum_q   <= '0;
         res_carry_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_in_q      <= c_in_d;
         res_sum_q   <= res_sum_d;
         res_carry_q <= res_carry_d;
      end
   end

`ifdef LOADER_OVF_EN
   logic res_ovf_q, res_ovf_d;

   // Signed overflow: same-sign operands producing an opposite-sign sum
   always_comb begin
      res_ovf_d = res_ovf_q;
      if (state_q == ADD)
         res_ovf_d = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (sum[DATA_W-1] != a_q[DATA_W-1]);
   end

   // Overflow flag register, captured alongside res_sum
   always_ff @(posedge clk or posedge rst) begin
      if (rst) res_ovf_q <= 1'b0;
      else     res_ovf_q <= res_ovf_d;
   end

   assign res_ovf = res_ovf_q;
`else
   assign res_ovf = 1'b0;
`endif

   // Handshake outputs decode from state only: no path from in_valid/res_ready
   assign in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
   assign res_valid = (state_q == HOLD);

   assign a         = a_q;
   assign b         = b_q;
   assign c_in      = c_in_q;
   assign res_sum   = res_sum_q;
   assign res_carry = res_carry_q;

endmodule
